// File: rtl/number_decoder.sv
// Multi-cycle number-format decoder: SM/C1/C2/BCD/XS3/2-of-5 to 8-bit magnitude + sign.
// Optional feature macro: DECODE_2OF5_EN enables the 2-of-5 (63210/74210) tables.
module number_decoder #(
    parameter int BCD_ITER = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  format_in,
    input  logic [11:0] code_in,
    input  logic        sign_in,
    output logic [7:0]  n_out,
    output logic        sign_out,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] F_SM  = 3'b000;
    localparam logic [2:0] F_C1  = 3'b001;
    localparam logic [2:0] F_C2  = 3'b010;
    localparam logic [2:0] F_BCD = 3'b011;
    localparam logic [2:0] F_XS3 = 3'b100;
`ifdef DECODE_2OF5_EN
    localparam logic [2:0] F_63  = 3'b101;
    localparam logic [2:0] F_74  = 3'b110;
`endif

    localparam int CW = $clog2(BCD_ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [2:0]    fmt_q;
    logic [7:0]    code_q;
    logic          sgn_q;
    logic [19:0]   sh_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          bcd_ok;
    logic          xs3_ok;
    logic          use_shift;
    logic [11:0]   load_bcd;
    logic [19:0]   sh_nx;
    logic [7:0]    calc_n;
    logic          calc_s;
    logic          calc_e;

`ifdef DECODE_2OF5_EN
    // 63210 weighted 2-of-5 table; bit 4 flags a valid pattern
    function automatic logic [4:0] dec_63210(input logic [4:0] c);
        logic [4:0] r;
        unique case (c)
            5'b01100: r = 5'h10;
            5'b11000: r = 5'h11;
            5'b10100: r = 5'h12;
            5'b10010: r = 5'h13;
            5'b01010: r = 5'h14;
            5'b00110: r = 5'h15;
            5'b10001: r = 5'h16;
            5'b01001: r = 5'h17;
            5'b00101: r = 5'h18;
            5'b00011: r = 5'h19;
            default:  r = 5'h00;
        endcase
        return r;
    endfunction

    // 74210 weighted 2-of-5 table; bit 4 flags a valid pattern
    function automatic logic [4:0] dec_74210(input logic [4:0] c);
        logic [4:0] r;
        unique case (c)
            5'b11000: r = 5'h10;
            5'b00011: r = 5'h11;
            5'b00101: r = 5'h12;
            5'b00110: r = 5'h13;
            5'b01001: r = 5'h14;
            5'b01010: r = 5'h15;
            5'b01100: r = 5'h16;
            5'b10001: r = 5'h17;
            5'b10010: r = 5'h18;
            5'b10100: r = 5'h19;
            default:  r = 5'h00;
        endcase
        return r;
    endfunction

    logic [4:0] d63;
    logic [4:0] d74;
`endif

    assign accept = en && (state == IDLE || state == DONE);

    // Digit screening and load value for the reverse double-dabble
    always_comb begin
        bcd_ok   = 1'b1;
        xs3_ok   = 1'b1;
        load_bcd = code_in;
        for (int d = 0; d < 3; d++) begin
            if (code_in[4*d +: 4] > 4'd9)
                bcd_ok = 1'b0;
            if (code_in[4*d +: 4] < 4'd3 || code_in[4*d +: 4] > 4'd12)
                xs3_ok = 1'b0;
        end
        if (format_in == F_XS3) begin
            for (int d = 0; d < 3; d++)
                load_bcd[4*d +: 4] = code_in[4*d +: 4] - 4'd3;
        end
        use_shift = (format_in == F_BCD && bcd_ok) ||
                    (format_in == F_XS3 && xs3_ok);
    end

    // One reverse double-dabble step: shift right, then fix digits >= 8
    always_comb begin
        sh_nx = sh_q >> 1;
        for (int d = 0; d < 3; d++) begin
            if (sh_nx[8 + 4*d +: 4] >= 4'd8)
                sh_nx[8 + 4*d +: 4] = sh_nx[8 + 4*d +: 4] - 4'd3;
        end
    end

`ifdef DECODE_2OF5_EN
    assign d63 = dec_63210(code_q[4:0]);
    assign d74 = dec_74210(code_q[4:0]);
`endif

    // Single-cycle formats and early-error results, from latched inputs
    always_comb begin
        calc_n = 8'd0;
        calc_s = 1'b0;
        calc_e = 1'b0;
        unique case (fmt_q)
            F_SM: begin
                calc_s = code_q[7];
                calc_n = {1'b0, code_q[6:0]};
            end
            F_C1: begin
                calc_s = code_q[7];
                calc_n = code_q[7] ? ~code_q : code_q;
            end
            F_C2: begin
                calc_s = code_q[7];
                calc_n = code_q[7] ? (~code_q + 8'd1) : code_q;
            end
            F_BCD, F_XS3: begin
                // Only reached here when a digit was out of range
                calc_s = sgn_q;
                calc_e = 1'b1;
            end
`ifdef DECODE_2OF5_EN
            F_63: begin
                calc_s = sgn_q;
                calc_e = ~d63[4];
                calc_n = {4'd0, d63[3:0]};
            end
            F_74: begin
                calc_s = sgn_q;
                calc_e = ~d74[4];
                calc_n = {4'd0, d74[3:0]};
            end
`endif
            default: begin
                calc_e = 1'b1;
            end
        endcase
    end

    // Control FSM with registered result, strobe and busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fmt_q    <= 3'd0;
            code_q   <= 8'd0;
            sgn_q    <= 1'b0;
            sh_q     <= 20'd0;
            cnt_q    <= '0;
            n_out    <= 8'd0;
            sign_out <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        fmt_q  <= format_in;
                        code_q <= code_in[7:0];
                        sgn_q  <= sign_in;
                        sh_q   <= {load_bcd, 8'd0};
                        cnt_q  <= '0;
                        busy   <= 1'b1;
                        state  <= use_shift ? SHIFT : CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    n_out    <= calc_n;
                    sign_out <= calc_s;
                    err      <= calc_e;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                SHIFT: begin
                    if (cnt_q == CW'(BCD_ITER)) begin
                        // Residual BCD means the value exceeded 255
                        n_out    <= sh_q[7:0];
                        sign_out <= sgn_q;
                        err      <= |sh_q[19:8];
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        sh_q  <= sh_nx;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_number_decoder.sv
// Directed self-checking bench for number_decoder.
// Honours DECODE_2OF5_EN to pick the expected 2-of-5 behaviour.
module tb_number_decoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  format_in;
    logic [11:0] code_in;
    logic        sign_in;
    logic [7:0]  n_out;
    logic        sign_out;
    logic        valid;
    logic        busy;
    logic        err;

    int n_vec;
    int n_bad;

    number_decoder #(.BCD_ITER(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .format_in (format_in),
        .code_in   (code_in),
        .sign_in   (sign_in),
        .n_out     (n_out),
        .sign_out  (sign_out),
        .valid     (valid),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start one operation, scramble inputs after accept, wait for valid
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [11:0] c, input logic s,
                          output int lat);
        @(negedge clk);
        format_in = f;
        code_in   = c;
        sign_in   = s;
        en        = 1'b1;
        @(negedge clk);
        en        = 1'b0;
        format_in = f ^ 3'b011;
        code_in   = ~c;
        sign_in   = ~s;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_vec(input string tag, input logic [2:0] f,
                          input logic [11:0] c, input logic s,
                          input logic [7:0] en_n, input logic es,
                          input logic ee, input int elat);
        int lat;
        run_op(tag, f, c, s, lat);
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        check({tag, ".err"}, 32'(err), 32'(ee));
        check({tag, ".n"}, 32'(n_out), 32'(en_n));
        check({tag, ".sign"}, 32'(sign_out), 32'(es));
    endtask

    initial begin
        int lat;
        int vcnt;
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        en        = 1'b0;
        format_in = 3'd0;
        code_in   = 12'd0;
        sign_in   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.n", 32'(n_out), 32'd0);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.sign", 32'(sign_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_vec("bcd255", 3'b011, 12'h255, 1'b0, 8'd255, 1'b0, 1'b0, 9);
        do_vec("bcd256", 3'b011, 12'h256, 1'b0, 8'd0, 1'b0, 1'b1, 9);
        do_vec("bcd1a3", 3'b011, 12'h1A3, 1'b0, 8'd0, 1'b0, 1'b1, 1);
        do_vec("bcd042", 3'b011, 12'h042, 1'b1, 8'd42, 1'b1, 1'b0, 9);
        do_vec("xs3456", 3'b100, 12'h456, 1'b0, 8'd123, 1'b0, 1'b0, 9);
        do_vec("xs3126", 3'b100, 12'h126, 1'b0, 8'd0, 1'b0, 1'b1, 1);
        do_vec("c2_80", 3'b010, 12'h080, 1'b0, 8'd128, 1'b1, 1'b0, 1);
        do_vec("c2_fb", 3'b010, 12'h0FB, 1'b0, 8'd5, 1'b1, 1'b0, 1);
        do_vec("c2_05", 3'b010, 12'h005, 1'b0, 8'd5, 1'b0, 1'b0, 1);
        do_vec("c1_ff", 3'b001, 12'h0FF, 1'b0, 8'd0, 1'b1, 1'b0, 1);
        do_vec("c1_fa", 3'b001, 12'h0FA, 1'b0, 8'd5, 1'b1, 1'b0, 1);
        do_vec("sm_85", 3'b000, 12'h085, 1'b0, 8'd5, 1'b1, 1'b0, 1);
        do_vec("sm_80", 3'b000, 12'h080, 1'b0, 8'd0, 1'b1, 1'b0, 1);
        do_vec("resv", 3'b111, 12'h055, 1'b1, 8'd0, 1'b0, 1'b1, 1);
`ifdef DECODE_2OF5_EN
        do_vec("t63_0", 3'b101, 12'h00C, 1'b0, 8'd0, 1'b0, 1'b0, 1);
        do_vec("t63_7", 3'b101, 12'h009, 1'b1, 8'd7, 1'b1, 1'b0, 1);
        do_vec("t74_9", 3'b110, 12'h014, 1'b0, 8'd9, 1'b0, 1'b0, 1);
        do_vec("t63bad", 3'b101, 12'h007, 1'b0, 8'd0, 1'b0, 1'b1, 1);
`else
        do_vec("t63off", 3'b101, 12'h00C, 1'b1, 8'd0, 1'b0, 1'b1, 1);
        do_vec("t74off", 3'b110, 12'h014, 1'b1, 8'd0, 1'b0, 1'b1, 1);
`endif

        // en pulsed during SHIFT must be ignored
        @(negedge clk);
        format_in = 3'b011;
        code_in   = 12'h100;
        sign_in   = 1'b0;
        en        = 1'b1;
        vcnt      = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) vcnt++;
            en = (i == 3);
            if (i == 3) begin
                format_in = 3'b010;
                code_in   = 12'h005;
            end
        end
        check("ignore.vcnt", 32'(vcnt), 32'd1);
        check("ignore.n", 32'(n_out), 32'd100);
        check("ignore.err", 32'(err), 32'd0);

        // Back-to-back: new en in the DONE cycle
        do_vec("b2b1", 3'b010, 12'h0FB, 1'b0, 8'd5, 1'b1, 1'b0, 1);
        format_in = 3'b000;
        code_in   = 12'h003;
        sign_in   = 1'b0;
        en        = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("b2b2.busy", 32'(busy), 32'd1);
        check("b2b2.valid", 32'(valid), 32'd0);
        lat = 0;
        while (!valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("b2b2.lat", 32'(lat), 32'd1);
        check("b2b2.n", 32'(n_out), 32'd3);
        check("b2b2.sign", 32'(sign_out), 32'd0);

        // Reset at SHIFT edge 4 aborts with no valid
        @(negedge clk);
        format_in = 3'b011;
        code_in   = 12'h199;
        sign_in   = 1'b1;
        en        = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort.n", 32'(n_out), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.valid", 32'(valid), 32'd0);
        check("abort.sign", 32'(sign_out), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        check("abort.vcnt", 32'(vcnt), 32'd0);

        do_vec("post", 3'b011, 12'h199, 1'b1, 8'd199, 1'b1, 1'b0, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
